// File: rtl/spm_access_ctrl_if.sv
// Request/response and scratchpad-memory signal bundle for spm_access_ctrl.
// master = pipeline + SPM side, slave = the access controller.
interface spm_access_ctrl_if;
  logic        req_;
  logic        req_rw;
  logic [13:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wr_data;
  logic        busy;
  logic        ack;
  logic        err;
  logic [31:0] rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data;

  modport master (
    output req_, req_rw, req_addr, req_size, req_signed, req_wr_data, spm_rd_data,
    input  busy, ack, err, rd_data, spm_addr, spm_as_, spm_rw, spm_wr_data
  );

  modport slave (
    input  req_, req_rw, req_addr, req_size, req_signed, req_wr_data, spm_rd_data,
    output busy, ack, err, rd_data, spm_addr, spm_as_, spm_rw, spm_wr_data
  );
endinterface

// File: rtl/spm_access_ctrl.sv
// Scratchpad access controller: single-outstanding loads/stores, word load 2 cycles, word store 1, sub-word store (RMW) 3.
// Requests arriving while busy are dropped; SPM_ACCESS_SUBWORD_EN enables byte/halfword access.
module spm_access_ctrl (
  input logic              clk,
  input logic              rst_,
  spm_access_ctrl_if.slave bus
);

`ifdef SPM_ACCESS_SUBWORD_EN
  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR} state_t;
`else
  typedef enum logic [0:0] {IDLE, LD_WAIT} state_t;
`endif

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        is_ld_q, is_ld_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        as_q, as_d;
  logic        rw_q, rw_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] wdat_q, wdat_d;
  logic [11:0] addr_q, addr_d;
  logic        illegal;

`ifdef SPM_ACCESS_SUBWORD_EN
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] m;
    m = w;
    if (size == 2'b00)
      m[{lane, 3'b000} +: 8] = d[7:0];
    else
      m[{lane[1], 4'b0000} +: 16] = d;
    return m;
  endfunction

  always_comb begin
    illegal = 1'b0;
    case (bus.req_size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = bus.req_addr[0];
      2'b10:   illegal = |bus.req_addr[1:0];
      default: illegal = 1'b1;
    endcase
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.req_signed};

  always_comb begin
    illegal = (bus.req_size != 2'b10) || (|bus.req_addr[1:0]);
  end
`endif

  // Word stores reuse LD_WAIT with pend clear, so they complete one cycle after the strobe.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    is_ld_d = is_ld_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    as_d    = 1'b1;
    rw_d    = rw_q;
    rd_d    = rd_q;
    wdat_d  = wdat_q;
    addr_d  = addr_q;
`ifdef SPM_ACCESS_SUBWORD_EN
    lane_d  = lane_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.req_) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.req_addr[13:2];
            is_ld_d = bus.req_rw;
`ifdef SPM_ACCESS_SUBWORD_EN
            lane_d  = bus.req_addr[1:0];
            size_d  = bus.req_size;
            sgn_d   = bus.req_signed;
`endif
            if (bus.req_rw) begin
              as_d    = 1'b0;
              rw_d    = 1'b1;
              pend_d  = 1'b1;
              state_d = LD_WAIT;
            end
`ifdef SPM_ACCESS_SUBWORD_EN
            else if (bus.req_size != 2'b10) begin
              // store data parks in the write-data register until the merge
              as_d    = 1'b0;
              rw_d    = 1'b1;
              pend_d  = 1'b1;
              wdat_d  = bus.req_wr_data;
              state_d = RMW_RD;
            end
`endif
            else begin
              as_d    = 1'b0;
              rw_d    = 1'b0;
              pend_d  = 1'b0;
              wdat_d  = bus.req_wr_data;
              state_d = LD_WAIT;
            end
          end
        end
      end
      LD_WAIT: begin
        if (pend_q) begin
          pend_d = 1'b0;
        end else begin
          ack_d   = 1'b1;
          state_d = IDLE;
          if (is_ld_q) begin
`ifdef SPM_ACCESS_SUBWORD_EN
            rd_d = load_extract(bus.spm_rd_data, lane_q, size_q, sgn_q);
`else
            rd_d = bus.spm_rd_data;
`endif
          end
        end
      end
`ifdef SPM_ACCESS_SUBWORD_EN
      RMW_RD: begin
        if (pend_q) begin
          pend_d = 1'b0;
        end else begin
          wdat_d  = store_merge(bus.spm_rd_data, wdat_q[15:0], lane_q, size_q);
          as_d    = 1'b0;
          rw_d    = 1'b0;
          state_d = RMW_WR;
        end
      end
      RMW_WR: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      is_ld_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      as_q    <= 1'b1;
      rw_q    <= 1'b1;
      rd_q    <= '0;
      wdat_q  <= '0;
      addr_q  <= '0;
`ifdef SPM_ACCESS_SUBWORD_EN
      lane_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      is_ld_q <= is_ld_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      as_q    <= as_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      wdat_q  <= wdat_d;
      addr_q  <= addr_d;
`ifdef SPM_ACCESS_SUBWORD_EN
      lane_q  <= lane_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.rd_data     = rd_q;
  assign bus.spm_addr    = addr_q;
  assign bus.spm_as_     = as_q;
  assign bus.spm_rw      = rw_q;
  assign bus.spm_wr_data = wdat_q;

endmodule

// File: tb/tb_spm_access_ctrl.sv
// Bench for spm_access_ctrl: SPM memory model, arithmetic reference model, scoreboard queue and monitor.
module tb_spm_access_ctrl;
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  spm_access_ctrl_if bus();
  spm_access_ctrl dut (.clk(clk), .rst_(rst_), .bus(bus));

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  bit   [31:0] mem[4096];
  bit   [31:0] ref_mem[4096];
  int          cyc = 0;
  int          n_rd = 0, n_wr = 0;
  int          exp_rd = 0, exp_wr = 0;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] model_rd = '0;
  bit          prev_as_low = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPM: strobe sampled on the edge, read data presented for the following cycle
  always @(posedge clk) begin
    if (!bus.spm_as_) begin
      if (bus.spm_rw) begin
        bus.spm_rd_data <= mem[bus.spm_addr];
        n_rd <= n_rd + 1;
      end else begin
        mem[bus.spm_addr] <= bus.spm_wr_data;
        n_wr <= n_wr + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_) begin
      if (!bus.spm_as_) chk("strobe_one_cycle", {31'd0, prev_as_low}, 32'd0);
      prev_as_low = !bus.spm_as_;
      if (bus.ack || bus.err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {30'd0, bus.ack, bus.err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_kind", {30'd0, bus.ack, bus.err}, e.is_err ? 32'd1 : 32'd2);
          chk("resp_cycle", cyc, e.cyc);
          chk("rd_data", bus.rd_data, e.data);
        end
      end
    end else begin
      prev_as_low = 1'b0;
    end
  end

  function automatic bit model_illegal(input logic [13:0] a, input logic [1:0] sz);
`ifdef SPM_ACCESS_SUBWORD_EN
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz == 2'd2) return (a % 4) != 0;
    return 1'b0;
`else
    return !(sz == 2'd2 && (a % 4) == 0);
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [13:0] a, input logic [1:0] sz, input bit sg);
    longint unsigned w, v, m;
    int nb, sh;
    nb = 1 << sz;
    sh = 8 * int'(a % 4);
    w  = ref_mem[a / 4];
    m  = (64'd1 << (8 * nb)) - 1;
    v  = (w >> sh) & m;
    if (sg && nb < 4 && v >= (m + 1) / 2) v = v | (64'hFFFF_FFFF & ~m);
    return 32'(v);
  endfunction

  function automatic void model_store(input logic [13:0] a, input logic [1:0] sz, input logic [31:0] d);
    longint unsigned w, m, dd;
    int nb, sh;
    nb = 1 << sz;
    sh = 8 * int'(a % 4);
    w  = ref_mem[a / 4];
    dd = d;
    m  = ((64'd1 << (8 * nb)) - 1) << sh;
    ref_mem[a / 4] = 32'((w & ~m) | ((dd << sh) & m));
  endfunction

  task automatic scramble();
    bus.req_rw      = 1'($urandom);
    bus.req_addr    = 14'($urandom);
    bus.req_size    = 2'($urandom);
    bus.req_signed  = 1'($urandom);
    bus.req_wr_data = $urandom;
  endtask

  // Called at a negedge with busy low; returns at a negedge with busy low.
  task automatic do_req(input bit rw, input logic [13:0] a, input logic [1:0] sz, input bit sg,
                        input logic [31:0] d, input bit hold, input bit b2b);
    exp_t e;
    int   c0, lat, n;
    bit   bad;
    bad = model_illegal(a, sz);
    c0  = cyc + 1;
    if (bad) lat = 0;
    else if (rw) begin lat = 2; exp_rd++; model_rd = model_load(a, sz, sg); end
    else if (sz == 2'd2) begin lat = 1; exp_wr++; model_store(a, sz, d); end
    else begin lat = 3; exp_rd++; exp_wr++; model_store(a, sz, d); end
    e.is_err = bad;
    e.data   = model_rd;
    e.cyc    = c0 + lat;
    exp_q.push_back(e);
    bus.req_        = 1'b0;
    bus.req_rw      = rw;
    bus.req_addr    = a;
    bus.req_size    = sz;
    bus.req_signed  = sg;
    bus.req_wr_data = d;
    @(negedge clk);
    if (bad) begin
      chk("err_busy_low", {31'd0, bus.busy}, 32'd0);
      chk("err_no_strobe", {31'd0, bus.spm_as_}, 32'd1);
    end
    if (!hold) bus.req_ = 1'b1;
    n = 0;
    while (bus.busy && n < 20) begin
      if (hold) scramble();
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("busy_timeout", {31'd0, bus.busy}, 32'd0);
    bus.req_ = 1'b1;
    if (!b2b) begin
      @(negedge clk);
      chk("spm_reads", n_rd, exp_rd);
      chk("spm_writes", n_wr, exp_wr);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_ack"}, {31'd0, bus.ack}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_rd_data"}, bus.rd_data, 32'd0);
    chk({tag, "_spm_as_"}, {31'd0, bus.spm_as_}, 32'd1);
    chk({tag, "_spm_rw"}, {31'd0, bus.spm_rw}, 32'd1);
    chk({tag, "_spm_addr"}, {20'd0, bus.spm_addr}, 32'd0);
    chk({tag, "_spm_wr_data"}, bus.spm_wr_data, 32'd0);
  endtask

  // Start an access, then pulse reset k negedges after acceptance while it is in flight.
  task automatic reset_mid(input bit rw, input logic [13:0] a, input logic [1:0] sz,
                           input logic [31:0] d, input int k, input int rds, input bit exp_as);
    bus.req_        = 1'b0;
    bus.req_rw      = rw;
    bus.req_addr    = a;
    bus.req_size    = sz;
    bus.req_signed  = 1'b0;
    bus.req_wr_data = d;
    @(negedge clk);
    bus.req_ = 1'b1;
    repeat (k) @(negedge clk);
    chk("inflight_busy", {31'd0, bus.busy}, 32'd1);
    chk("inflight_strobe", {31'd0, bus.spm_as_}, {31'd0, exp_as});
    rst_ = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(negedge clk);
    rst_ = 1'b1;
    model_rd = '0;
    exp_rd += rds;
    repeat (3) @(negedge clk);
    chk("post_reset_reads", n_rd, exp_rd);
    chk("post_reset_writes", n_wr, exp_wr);
    chk("post_reset_word", mem[a / 4], ref_mem[a / 4]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_        = 1'b1;
    bus.req_rw      = 1'b0;
    bus.req_addr    = '0;
    bus.req_size    = 2'd2;
    bus.req_signed  = 1'b0;
    bus.req_wr_data = '0;
    #1 rst_ = 1'b0;
    #1 chk_reset("reset");
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);

    do_req(1'b0, 14'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("word_store_mem", mem[4], 32'hDEADBEEF);
    do_req(1'b1, 14'h010, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 14'h013, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 14'h011, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 14'h010, 2'd2, 1'b0, 32'h11223344, 1'b0, 1'b0);
    do_req(1'b0, 14'h012, 2'd0, 1'b0, 32'h000000A5, 1'b0, 1'b0);
`ifdef SPM_ACCESS_SUBWORD_EN
    chk("byte_store_mem", mem[4], 32'h11A53344);
    do_req(1'b0, 14'h010, 2'd2, 1'b0, 32'h8001FFFF, 1'b0, 1'b0);
    do_req(1'b1, 14'h012, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("half_signed", bus.rd_data, 32'hFFFF8001);
    do_req(1'b1, 14'h012, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("half_unsigned", bus.rd_data, 32'h00008001);
    do_req(1'b0, 14'h015, 2'd0, 1'b0, 32'h0000005A, 1'b1, 1'b0);
    reset_mid(1'b0, 14'h012, 2'd0, 32'h000000EE, 2, 1, 1'b0);
`else
    chk("byte_store_no_access", mem[4], 32'h11223344);
    do_req(1'b1, 14'h010, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    reset_mid(1'b1, 14'h010, 2'd2, 32'h0, 0, 0, 1'b0);
`endif
    do_req(1'b1, 14'h010, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1);
    do_req(1'b1, 14'h014, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 14'h018, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1);
    do_req(1'b1, 14'h018, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom_range(0, 3));
      do_req(1'($urandom), 14'($urandom_range(0, 63)), sz, 1'($urandom), $urandom,
             1'b0, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_reads", n_rd, exp_rd);
    chk("final_writes", n_wr, exp_wr);
    for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_mem[w]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spm_access_ctrl.md
SPM_ACCESS_CTRL -- requirements
Module: spm_access_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_  input  1  reset, asynchronous, active-low.
REQ-003 req_  input  1  active-low request strobe from pipeline; sampled only in IDLE.
REQ-004 req_rw  input  1  1 = READ (load), 0 = WRITE (store).
REQ-005 req_addr  input  14  byte address; bits [13:2] select SPM word, bits [1:0] select byte lane.
REQ-006 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-007 req_signed  input  1  loads only: 1 sign-extends, 0 zero-extends sub-word data.
REQ-008 req_wr_data  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 ack  output  1  one-cycle pulse on successful completion.
REQ-011 err  output  1  one-cycle pulse on a rejected request; no SPM access is made.
REQ-012 rd_data  output  32  load result, extended to 32 bits, valid while ack is high, held afterwards.
REQ-013 spm_addr  output  12  SPM word address.
REQ-014 spm_as_  output  1  active-low SPM address strobe.
REQ-015 spm_rw  output  1  1 = READ, 0 = WRITE.
REQ-016 spm_wr_data  output  32  full-word write data to SPM.
REQ-017 spm_rd_data  input  32  SPM read data, valid the cycle after a READ strobe is sampled.

Function
REQ-018 All spm_* outputs, ack, err and rd_data SHALL be registered; spm_as_ is low for exactly one cycle per SPM access.
REQ-019 States: IDLE, LD_WAIT, RMW_RD, RMW_WR; no other states are used.
REQ-020 Request is misaligned when halfword has req_addr[0]=1, word has req_addr[1:0]!=0, or size=11; it yields err the next cycle, and the state stays IDLE.
REQ-021 Load (IDLE, req_=0, rw=1): drive READ strobe next cycle and enter LD_WAIT; one cycle later capture spm_rd_data, select the lane (little-endian: lane 0 = [7:0], halfword at [1]=1 = [31:16]), extend, pulse ack, return IDLE; ack appears 2 cycles after the request edge.
REQ-022 Word store: drive WRITE strobe with req_wr_data next cycle, pulse ack on the following cycle, remain IDLE-able (busy for 1 cycle).
REQ-023 Sub-word store: RMW_RD issues a READ of the target word; after the data returns, RMW_WR merges req data into the selected lane(s) and issues the WRITE; ack appears 3 cycles after the request edge.
REQ-024 The address, size, signed flag and write data SHALL be latched at request acceptance; input changes while busy have no effect.
REQ-025 req_ asserted while busy SHALL be ignored (not queued); the requester re-presents after busy falls.
REQ-026 A new request is accepted in the same cycle that ack is high, provided busy is low.

Reset
REQ-027 On rst_=0: state IDLE, busy 0, ack 0, err 0, rd_data 0, spm_as_ 1, spm_rw 1, spm_addr 0, spm_wr_data 0, effective immediately, with no clock required.
REQ-028 Reset during RMW_RD/RMW_WR SHALL abort the operation: no write strobe issued after reset, no ack.

Configuration
REQ-029 Macro SPM_ACCESS_SUBWORD_EN: when defined, byte/halfword loads and stores operate per REQ-021/023.
REQ-030 When undefined, only size=10 is legal; any other size gets err; RMW states are removed.

Verification
REQ-031 Word store addr 0x010, data 0xDEADBEEF, then word load 0x010 -> SPM word 4 written, rd_data=0xDEADBEEF, ack 2 cycles after load request.
REQ-032 Byte store 0xA5 at 0x012 over word 0x11223344 -> exactly one READ then one WRITE of 0x11A53344 to word 4, ack 3 cycles after request.
REQ-033 Halfword load 0x012 with word 0x8001FFFF, signed -> 0xFFFF8001; unsigned -> 0x00008001.
REQ-034 Word load at 0x013 and halfword at 0x011 -> err pulse, spm_as_ stays high, busy stays 0.
REQ-035 req_ held low during an RMW -> only the first request is served, one ack; rst_ pulsed in RMW_WR -> outputs at reset values, memory word unchanged.
REQ-036 Macro undefined: byte store -> err, no SPM access.
